// File: rtl/io_input_conditioner.sv
// Synchronizes and debounces raw board switches and push-buttons into clean levels for the core.
// Optional macro IO_BTN_EVENT_EN adds registered one-cycle button press pulses on o_btn_press.
module io_input_conditioner #(
   parameter int unsigned NUM_SW          = 18,
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_sw_raw,
   input  logic [3:0]  i_btn_raw,
   output logic [31:0] o_io_sw,
   output logic [3:0]  o_io_btn,
   output logic [3:0]  o_btn_press
);

   localparam int unsigned NB = NUM_SW + 4;
   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   // Buttons idle at their released raw level, switches idle at 0.
   localparam logic [NB-1:0] RST_LVL = {{4{BTN_ACTIVE_LOW}}, {NUM_SW{1'b0}}};

   logic [NB-1:0] raw;
   logic [NB-1:0] s1_q;
   logic [NB-1:0] s2_q;
   logic [NB-1:0] st_q;
   logic [NB-1:0] st_d;
   logic [CW-1:0] cnt_q [NB];
   logic [CW-1:0] cnt_d [NB];
   logic [3:0]    st_btn;
   logic          unused_sw_raw;

   assign raw           = {i_btn_raw, i_sw_raw[NUM_SW-1:0]};
   assign unused_sw_raw = ^i_sw_raw;

   // A bit only moves once it has disagreed with st for DEBOUNCE_CYCLES consecutive cycles.
   always_comb begin
      st_d = st_q;
      for (int i = 0; i < int'(NB); i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != st_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               st_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         s1_q <= RST_LVL;
         s2_q <= RST_LVL;
         st_q <= RST_LVL;
         for (int i = 0; i < int'(NB); i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q <= raw;
         s2_q <= s1_q;
         st_q <= st_d;
         for (int i = 0; i < int'(NB); i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign st_btn = st_q[NB-1 -: 4];

   always_comb begin
      o_io_sw             = '0;
      o_io_sw[NUM_SW-1:0] = st_q[NUM_SW-1:0];
      o_io_btn            = BTN_ACTIVE_LOW ? ~st_btn : st_btn;
   end

`ifdef IO_BTN_EVENT_EN
   logic [3:0] btn_prev_q;
   logic [3:0] press_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         btn_prev_q <= 4'b0;
         press_q    <= 4'b0;
      end else begin
         btn_prev_q <= o_io_btn;
         press_q    <= o_io_btn & ~btn_prev_q;
      end
   end

   assign o_btn_press = press_q;
`else
   assign o_btn_press = 4'b0;
`endif

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with a window-based debounce model checked every cycle.
module tb_io_input_conditioner;

   localparam int unsigned DC = 4;
`ifdef IO_BTN_EVENT_EN
   localparam bit EV = 1'b1;
`else
   localparam bit EV = 1'b0;
`endif
   localparam logic [35:0] RST = {4'hF, 32'h0};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] sw_raw = 32'hFFFF_FFFF;
   logic [3:0]  btn_raw = 4'h0;
   logic [31:0] io_sw;
   logic [3:0]  io_btn;
   logic [3:0]  btn_press;

   int total = 0;
   int bad = 0;

   io_input_conditioner #(
      .NUM_SW         (18),
      .DEBOUNCE_CYCLES(DC),
      .BTN_ACTIVE_LOW (1'b1)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_sw_raw   (sw_raw),
      .i_btn_raw  (btn_raw),
      .o_io_sw    (io_sw),
      .o_io_btn   (io_btn),
      .o_btn_press(btn_press)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: raw is seen two edges late; a bit flips when the last DC seen samples all differ.
   logic [35:0] raw_hist[$];
   logic [35:0] win[$];
   logic [35:0] stable = RST;
   logic [35:0] syn;
   logic [3:0]  m_btn = 4'h0;
   logic [3:0]  m_btn_prev = 4'h0;
   logic [3:0]  m_press = 4'h0;
   bit          all_diff;
   bit          mvalid = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         raw_hist.delete();
         raw_hist.push_back(RST);
         raw_hist.push_back(RST);
         win.delete();
         stable     = RST;
         m_press    = 4'h0;
         m_btn_prev = 4'h0;
         mvalid     = 1'b1;
      end else begin
         m_press    = EV ? (m_btn & ~m_btn_prev) : 4'h0;
         m_btn_prev = m_btn;
         syn = raw_hist.pop_front();
         raw_hist.push_back({btn_raw, sw_raw});
         win.push_back(syn);
         if (win.size() > DC) void'(win.pop_front());
         if (win.size() == DC) begin
            for (int b = 0; b < 36; b++) begin
               all_diff = 1'b1;
               foreach (win[k]) if (win[k][b] == stable[b]) all_diff = 1'b0;
               if (all_diff) stable[b] = ~stable[b];
            end
         end
      end
      m_btn = ~stable[35:32];
   end

   always @(negedge clk) begin
      if (mvalid) begin
         chk("model_sw", io_sw, {14'b0, stable[17:0]});
         chk("model_btn", {28'b0, io_btn}, {28'b0, m_btn});
         chk("model_press", {28'b0, btn_press}, {28'b0, m_press});
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   int hi;
   int rises;
   int presses;
   logic prev0;

   initial begin
      // Reset held with all switches high and all buttons pressed.
      for (int i = 0; i < 4; i++) begin
         step(1);
         chk("rst_sw", io_sw, 32'h0);
         chk("rst_btn", {28'b0, io_btn}, 32'h0);
         chk("rst_press", {28'b0, btn_press}, 32'h0);
      end

      // Switch latency.
      rst_n = 1'b1;
      sw_raw = 32'h0000_0005;
      btn_raw = 4'hF;
      step(5);
      chk("lat_e5", io_sw, 32'h0);
      step(1);
      chk("lat_e6", io_sw, 32'h5);
      sw_raw = 32'hFFFF_FFFF;
      step(8);
      chk("sw_all", io_sw, 32'h0003_FFFF);

      // Glitches on bit 0.
      sw_raw = 32'h0;
      step(8);
      chk("sw_clear", io_sw, 32'h0);
      sw_raw = 32'h1;
      step(3);
      sw_raw = 32'h0;
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (io_sw[0]) hi++;
      end
      chk("glitch3_hi", hi, 0);
      sw_raw = 32'h1;
      step(4);
      sw_raw = 32'h0;
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (io_sw[0]) hi++;
      end
      chk("glitch4_width", hi, 4);

      // Button 1 press and release.
      btn_raw = 4'b1101;
      step(5);
      chk("btn_e5", {28'b0, io_btn}, 32'h0);
      step(1);
      chk("btn_e6", {28'b0, io_btn}, 32'h2);
      step(1);
      chk("btn_pulse", {28'b0, btn_press}, EV ? 32'h2 : 32'h0);
      step(1);
      chk("btn_pulse_end", {28'b0, btn_press}, 32'h0);
      btn_raw = 4'hF;
      presses = 0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (btn_press != 4'h0) presses++;
      end
      chk("release_no_pulse", presses, 0);
      chk("btn_released", {28'b0, io_btn}, 32'h0);

      // Reset mid-debounce.
      sw_raw = 32'h8;
      step(3);
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("mid_rst_sw3", {31'b0, io_sw[3]}, 32'h0);
      end
      rst_n = 1'b1;
      presses = 0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         if (btn_press != 4'h0) presses++;
      end
      chk("post_rst_e5", {31'b0, io_sw[3]}, 32'h0);
      step(1);
      chk("post_rst_e6", {31'b0, io_sw[3]}, 32'h1);
      chk("post_rst_press", presses, 0);

      // Bounce train on button 0, ending pressed.
      rises = 0;
      presses = 0;
      prev0 = io_btn[0];
      for (int k = 0; k < 20; k++) begin
         btn_raw[0] = ~btn_raw[0];
         for (int j = 0; j < 2; j++) begin
            step(1);
            if (io_btn[0] && !prev0) rises++;
            prev0 = io_btn[0];
         end
      end
      chk("bounce_no_rise", rises, 0);
      btn_raw[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         if (io_btn[0] && !prev0) rises++;
         prev0 = io_btn[0];
      end
      chk("bounce_e5", {31'b0, io_btn[0]}, 32'h0);
      step(1);
      chk("bounce_e6", {31'b0, io_btn[0]}, 32'h1);
      if (io_btn[0] && !prev0) rises++;
      prev0 = io_btn[0];
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (btn_press[0]) presses++;
         if (io_btn[0] && !prev0) rises++;
         prev0 = io_btn[0];
      end
      chk("bounce_rises", rises, 1);
      chk("bounce_presses", presses, EV ? 1 : 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
